// File: rtl/quad_decoder.sv
// Quadrature A/B decoder: input synchroniser, persistence filter, Gray-code step
// decode and a wrapping up/down position counter. All outputs are registered.
module quad_decoder #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT        = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             err_clr,
  input  logic             a_in,
  input  logic             b_in,
  output logic [WIDTH-1:0] cnt,
  output logic             dir,
  output logic             step,
  output logic             err
);

  localparam int unsigned FCW = $clog2(FILT + 1);

  logic [SYNC_STAGES-1:0][1:0] sync_q, sync_d;
  logic [1:0]                  s;
  logic [1:0]                  f_q, f_d;
  logic [FCW-1:0]              fcnt_q, fcnt_d;
  logic [1:0]                  p_q, p_d;
  logic                        valid_q, valid_d;
  logic [WIDTH-1:0]            cnt_q, cnt_d;
  logic                        dir_q, dir_d;
  logic                        step_q, step_d;
  logic                        err_q, err_d;

  // Shift raw {A,B} through the synchroniser chain.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], {a_in, b_in}};
    s      = sync_q[SYNC_STAGES-1];
  end

  // Accept a new synchronised value only after it has persisted FILT cycles.
  always_comb begin
    f_d    = f_q;
    fcnt_d = '0;
    if (s != f_q) begin
      if (fcnt_q == FCW'(FILT - 1)) begin
        f_d = s;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  // Decode each accepted phase change into up/down/illegal and update the count.
  always_comb begin
    p_d     = p_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    step_d  = 1'b0;
    err_d   = err_q;
    if (err_clr) begin
      err_d = 1'b0;
    end
    if (f_q != p_q) begin
      p_d = f_q;
      if (!valid_q) begin
        // First accepted value after reset only seeds the reference phase.
        valid_d = 1'b1;
      end else begin
        case ({p_q, f_q})
          4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: begin
            dir_d = 1'b1;
            if (en) begin
              cnt_d  = cnt_q + 1'b1;
              step_d = 1'b1;
            end
          end
          4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: begin
            dir_d = 1'b0;
            if (en) begin
              cnt_d  = cnt_q - 1'b1;
              step_d = 1'b1;
            end
          end
          // Both phases flipped at once: direction unknown, flag it (set beats clear).
          default: err_d = 1'b1;
        endcase
      end
    end
    if (clr) begin
      cnt_d  = '0;
      step_d = 1'b0;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      f_q     <= '0;
      fcnt_q  <= '0;
      p_q     <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      step_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      f_q     <= f_d;
      fcnt_q  <= fcnt_d;
      p_q     <= p_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
      err_q   <= err_d;
    end
  end

  assign cnt  = cnt_q;
  assign dir  = dir_q;
  assign step = step_q;
  assign err  = err_q;

endmodule
